serial_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 31 +++
 rtl/serial_alu_slice.sv | 46 ++++
 rtl/serial_alu.sv | 173 +++++++++++++++++
 tb/tb_serial_alu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALUControl interface. These are the codes the ALU
// decoder emits and the serial execution unit consumes. The package also holds
// the state encoding of the serial ALU control FSM.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   function automatic logic alu_code_legal(input logic [2:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_OR) ||
             (op == ALU_AND) || (op == ALU_SLT);
   endfunction

   // SUB and SLT both run as A + ~B + 1 through the digit adder.
   function automatic logic alu_code_subtracts(input logic [2:0] op);
      return (op == ALU_SUB) || (op == ALU_SLT);
   endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// ---------------------------------------------------------------------------
// serial_alu_slice
// Combinational DIGIT-bit datapath slice of the serial ALU.
//   a, b      : operand digits
//   carry_in  : carry from the previous (less significant) digit
//   op        : ALUControl code
//   digit     : sum / difference / logic result digit
//   carry_out : carry into the next digit (0 for logic ops)
// ---------------------------------------------------------------------------
module serial_alu_slice
   import alu_pkg::*;
#(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             carry_in,
   input  logic [2:0]       op,
   output logic [DIGIT-1:0] digit,
   output logic             carry_out
);

   logic [DIGIT:0] sum;

   always_comb begin
      sum       = '0;
      digit     = '0;
      carry_out = 1'b0;
      case (op)
         ALU_ADD: begin
            sum       = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, carry_in};
            digit     = sum[DIGIT-1:0];
            carry_out = sum[DIGIT];
         end
         ALU_SUB, ALU_SLT: begin
            sum       = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, carry_in};
            digit     = sum[DIGIT-1:0];
            carry_out = sum[DIGIT];
         end
         ALU_OR:  digit = a | b;
         ALU_AND: digit = a & b;
         default: ;
      endcase
   end

endmodule

// File: rtl/serial_alu.sv
// ---------------------------------------------------------------------------
// serial_alu
// Digit-serial execution unit for the ALUControl interface. It processes DIGIT
// bits per cycle, LSB first, and takes WIDTH/DIGIT BUSY cycles per legal
// operation. Illegal codes complete at once with result 0 and illegal=1.
//   clk, reset              : clock, asynchronous active-high reset
//   in_valid / in_ready     : request handshake (in_ready high only in IDLE)
//   alu_control, src_a/b    : operation code and operands, latched on accept
//   out_valid / out_ready   : result handshake; outputs frozen until accepted
//   result, zero, illegal   : operation result, result==0, unsupported code
// WIDTH must be a multiple of DIGIT and larger than DIGIT.
// ---------------------------------------------------------------------------
module serial_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   alu_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]       op_q, op_d;
   logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zero_q, zero_d, illegal_q, illegal_d;
   logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

   logic [DIGIT-1:0] slice_digit;
   logic             slice_carry;
   logic             lt;

   // Operands are shifted right each BUSY cycle, so the digit under work is
   // always the low digit; the sign bits are kept aside for SLT.
   serial_alu_slice #(.DIGIT(DIGIT)) u_slice (
      .a         (a_q[DIGIT-1:0]),
      .b         (b_q[DIGIT-1:0]),
      .carry_in  (carry_q),
      .op        (op_q),
      .digit     (slice_digit),
      .carry_out (slice_carry)
   );

   // Signed less-than: differing signs decide directly, otherwise the sign of
   // the difference (no overflow is possible when the signs match).
   assign lt = (a_msb_q != b_msb_q) ? a_msb_q : slice_digit[DIGIT-1];

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      a_msb_d     = a_msb_q;
      b_msb_d     = b_msb_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = src_a;
               b_d        = src_b;
               op_d       = alu_control;
               a_msb_d    = src_a[WIDTH-1];
               b_msb_d    = src_b[WIDTH-1];
               res_d      = '0;
               zero_d     = 1'b1;
               in_ready_d = 1'b0;
               if (alu_code_legal(alu_control)) begin
                  state_d   = BUSY;
                  cnt_d     = '0;
                  carry_d   = alu_code_subtracts(alu_control);
                  illegal_d = 1'b0;
               end else begin
                  state_d     = DONE;
                  illegal_d   = 1'b1;
                  out_valid_d = 1'b1;
               end
            end
         end
         BUSY: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = slice_carry;
            cnt_d   = cnt_q + 1'b1;
            // Digits enter at the MSB end; after N shifts digit 0 sits at the LSB.
            res_d   = {slice_digit, res_q[WIDTH-1:DIGIT]};
            zero_d  = zero_q & ~(|slice_digit);
            if (cnt_q == LAST) begin
               state_d     = DONE;
               cnt_d       = '0;
               out_valid_d = 1'b1;
               if (op_q == ALU_SLT) begin
                  res_d  = {{(WIDTH-1){1'b0}}, lt};
                  zero_d = ~lt;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         res_q       <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         a_msb_q     <= a_msb_d;
         b_msb_q     <= b_msb_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = res_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_serial_alu.sv
// ---------------------------------------------------------------------------
// tb_serial_alu
// Bench for serial_alu (WIDTH=32, DIGIT=4). A monitor on the falling edge
// predicts handshake behaviour and results from plain arithmetic; a driver
// runs directed cases with literal expectations, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_serial_alu;

   localparam int WIDTH = 32;
   localparam int DIGIT = 4;
   localparam int N     = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       alu_control = 3'b000;
   logic [WIDTH-1:0] src_a = '0;
   logic [WIDTH-1:0] src_b = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;

   int tests = 0;
   int fails = 0;

   serial_alu #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk         (clk),
      .reset       (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .src_a       (src_a),
      .src_b       (src_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_legal(input logic [2:0] op);
      return op inside {3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
   endfunction

   function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b011:  return a | b;
         3'b100:  return a & b;
         3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return '0;
      endcase
   endfunction

   // Monitor: one outstanding request at most, predicted from the inputs seen
   // at the accepting edge.
   bit               inflight = 0;
   bit               exp_legal = 0;
   int               cyc = 0;
   logic [WIDTH-1:0] exp_res = '0;

   always @(negedge clk) begin
      if (rst) begin
         check("rst_in_ready", {31'd0, in_ready}, 32'd1);
         check("rst_out_valid", {31'd0, out_valid}, 32'd0);
         check("rst_result", result, 32'd0);
         check("rst_zero", {31'd0, zero}, 32'd0);
         check("rst_illegal", {31'd0, illegal}, 32'd0);
         inflight = 0;
      end else begin
         check("in_ready", {31'd0, in_ready}, {31'd0, !inflight});
         if (inflight) begin
            if (exp_legal)
               check("out_valid_lat", {31'd0, out_valid}, {31'd0, (cyc >= N)});
            else if (cyc >= 1)
               check("out_valid_ill", {31'd0, out_valid}, 32'd1);
            if (out_valid) begin
               check("result", result, exp_res);
               check("zero", {31'd0, zero}, {31'd0, (exp_res == 0)});
               check("illegal", {31'd0, illegal}, {31'd0, !exp_legal});
            end
            cyc++;
            if (out_valid && out_ready) inflight = 0;
         end else begin
            check("out_valid_idle", {31'd0, out_valid}, 32'd0);
            if (in_valid && in_ready) begin
               inflight  = 1;
               cyc       = 0;
               exp_legal = is_legal(alu_control);
               exp_res   = model(alu_control, src_a, src_b);
            end
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1; t++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL wait_in_ready: timed out after %0d cycles", t);
      end
   endtask

   // One transaction. Operands and code are scrambled while the unit works,
   // and out_ready is withheld for 'hold' cycles once the result appears.
   task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit chk,
                         input logic [WIDTH-1:0] er, input logic ez,
                         input logic ei, input int hold);
      int t = 0;
      wait_ready();
      in_valid = 1'b1; alu_control = op; src_a = a; src_b = b; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && t < 100) begin
         src_a = $urandom; src_b = $urandom; alu_control = 3'($urandom);
         @(posedge clk); #1; t++;
      end
      if (!out_valid) begin
         tests++; fails++;
         $display("FAIL out_valid_timeout: no result after %0d cycles", t);
      end else if (chk) begin
         if (is_legal(op)) check("latency", t, N);
         else check("latency_ill", {31'd0, (t <= 1)}, 32'd1);
         check("lit_result", result, er);
         check("lit_zero", {31'd0, zero}, {31'd0, ez});
         check("lit_illegal", {31'd0, illegal}, {31'd0, ei});
      end
      repeat (hold) begin
         src_a = $urandom; src_b = $urandom;
         @(posedge clk); #1;
      end
      if (chk && hold > 0) check("held_result", result, er);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   function automatic logic [WIDTH-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_op(3'b000, 32'd5, 32'd7, 1, 32'd12, 1'b0, 1'b0, 0);
      run_op(3'b001, 32'd3, 32'd3, 1, 32'd0, 1'b1, 1'b0, 0);
      run_op(3'b001, 32'd0, 32'd1, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
      run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1'b0, 1'b0, 0);
      run_op(3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 1, 32'd0, 1'b1, 1'b0, 0);
      run_op(3'b101, 32'h8000_0000, 32'h8000_0000, 1, 32'd0, 1'b1, 1'b0, 0);
      run_op(3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0, 1'b0, 1'b0, 5);
      run_op(3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'hFFF0_FFF0, 1'b0, 1'b0, 0);
      run_op(3'b010, 32'd9, 32'd4, 1, 32'd0, 1'b1, 1'b1, 2);
      run_op(3'b000, 32'd100, 32'd23, 1, 32'd123, 1'b0, 1'b0, 0);

      // Reset in the middle of BUSY aborts the operation immediately.
      wait_ready();
      in_valid = 1'b1; alu_control = 3'b000; src_a = 32'h1234_5678; src_b = 32'h1111_1111;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_result", result, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      run_op(3'b000, 32'd1, 32'd1, 1, 32'd2, 1'b0, 1'b0, 0);

      for (int i = 0; i < 150; i++) begin
         logic [2:0] op;
         op = (i % 8 == 7) ? 3'($urandom) : 3'($urandom_range(0, 7));
         run_op(op, pick_operand(), pick_operand(), 0, '0, 1'b0, 1'b0,
                int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
